// File: rtl/row_feeder_pkg.sv
// Shared types for the row_feeder frame sequencer: FSM state encoding and
// default geometry constants.
package row_feeder_pkg;

  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_MAX_DIM    = 1024;
  localparam int RF_PAD_WIDTH  = 3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_INIT = 3'd1,
    ST_TOP  = 3'd2,
    ST_LPAD = 3'd3,
    ST_DATA = 3'd4,
    ST_RPAD = 3'd5,
    ST_BOT  = 3'd6
  } state_t;

  // States whose beats are zero padding and depend only on out_en.
  function automatic logic is_pad_state(input state_t s);
    return (s == ST_TOP) || (s == ST_LPAD) || (s == ST_RPAD) || (s == ST_BOT);
  endfunction

endpackage

// File: rtl/row_feeder_dim_counter.sv
// Loadable up-counter: clears to zero, advances on en, wraps after `last`
// and flags the terminal count.
module dim_counter #(
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] last,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en) begin
      count_d = (count_q == last) ? '0 : count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;
  assign tc    = (count_q == last);

endmodule

// File: rtl/row_feeder.sv
// Frame sequencer: turns a raw pixel stream into a zero-padded raster stream
// for a row_buffer chain, with per-frame geometry latched on start.
module row_feeder import row_feeder_pkg::*; #(
  parameter int C_DATA_WIDTH = RF_DATA_WIDTH,
  parameter int C_MAX_DIM    = RF_MAX_DIM,
  parameter int C_DIM_WIDTH  = $clog2(C_MAX_DIM),
  parameter int C_PAD_WIDTH  = RF_PAD_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [C_DIM_WIDTH-1:0]  num_cols,
  input  logic [C_DIM_WIDTH-1:0]  num_rows,
  input  logic [C_PAD_WIDTH-1:0]  pad,
  input  logic [C_DATA_WIDTH-1:0] pixel_in,
  input  logic                    pixel_in_valid,
  output logic                    pixel_in_ready,
  input  logic                    out_en,
  output logic                    initialize,
  output logic [C_DIM_WIDTH-1:0]  delay,
  output logic [C_DATA_WIDTH-1:0] dataout,
  output logic                    dataout_valid,
  output logic                    busy,
  output logic                    done,
  output logic                    cfg_err
);

  // One extra bit so padded sizes up to C_MAX_DIM (and taller frames) fit.
  localparam int XW = C_DIM_WIDTH + 1;
  localparam logic [XW-1:0] MAX_DIM_X = XW'(C_MAX_DIM);

  state_t                  state_q, state_d;
  logic [C_DIM_WIDTH-1:0]  cols_q, cols_d, rows_q, rows_d;
  logic [C_PAD_WIDTH-1:0]  pad_q, pad_d;
  logic [XW-1:0]           w_q, w_d, h_q, h_d;
  logic [C_DATA_WIDTH-1:0] dataout_q, dataout_d;
  logic                    dataout_valid_q, dataout_valid_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    pend_done_q, pend_done_d;
  logic                    cfg_err_q, cfg_err_d;

  logic [XW-1:0] col, row, pad_x, lpad_last, data_last, img_last, req_w, req_h;
  logic          col_tc, row_tc, cnt_clear, beat;

  assign pad_x     = XW'(pad_q);
  assign lpad_last = pad_x - XW'(1);
  assign data_last = pad_x + XW'(cols_q) - XW'(1);
  assign img_last  = pad_x + XW'(rows_q) - XW'(1);
  assign req_w     = XW'(num_cols) + (XW'(pad) << 1);
  assign req_h     = XW'(num_rows) + (XW'(pad) << 1);

  dim_counter #(.WIDTH(XW)) u_col_cnt (
    .clk(clk), .rst(rst), .clear(cnt_clear), .en(beat),
    .last(w_q - XW'(1)), .count(col), .tc(col_tc)
  );

  dim_counter #(.WIDTH(XW)) u_row_cnt (
    .clk(clk), .rst(rst), .clear(cnt_clear), .en(beat && col_tc),
    .last(h_q - XW'(1)), .count(row), .tc(row_tc)
  );

  always_comb begin
    state_d         = state_q;
    cols_d          = cols_q;
    rows_d          = rows_q;
    pad_d           = pad_q;
    w_d             = w_q;
    h_d             = h_q;
    dataout_d       = dataout_q;
    dataout_valid_d = 1'b0;
    busy_d          = busy_q;
    done_d          = pend_done_q;
    pend_done_d     = 1'b0;
    cfg_err_d       = 1'b0;
    cnt_clear       = 1'b0;
    pixel_in_ready  = 1'b0;
    beat            = 1'b0;

    if (is_pad_state(state_q)) beat = out_en;

    case (state_q)
      ST_IDLE: begin
        cnt_clear = 1'b1;
        if (pend_done_q) busy_d = 1'b0;
        // busy_q still high here means the previous frame's done has not pulsed yet.
        if (start && !busy_q) begin
          if (num_cols == '0 || num_rows == '0) begin
            done_d = 1'b1;
          end else if (req_w > MAX_DIM_X) begin
            cfg_err_d = 1'b1;
          end else begin
            cols_d  = num_cols;
            rows_d  = num_rows;
            pad_d   = pad;
            w_d     = req_w;
            h_d     = req_h;
            busy_d  = 1'b1;
            state_d = ST_INIT;
          end
        end
      end
      ST_INIT: begin
        cnt_clear = 1'b1;
        state_d   = (pad_q != '0) ? ST_TOP : ST_DATA;
      end
      ST_TOP: begin
        if (beat && col_tc && row == lpad_last) state_d = ST_LPAD;
      end
      ST_LPAD: begin
        if (beat && col == lpad_last) state_d = ST_DATA;
      end
      ST_DATA: begin
        pixel_in_ready = out_en;
        beat           = out_en && pixel_in_valid;
        if (beat && col == data_last) begin
          if (pad_q != '0) begin
            state_d = ST_RPAD;
          end else if (row_tc) begin
            state_d     = ST_IDLE;
            pend_done_d = 1'b1;
          end
        end
      end
      ST_RPAD: begin
        if (beat && col_tc) state_d = (row == img_last) ? ST_BOT : ST_LPAD;
      end
      ST_BOT: begin
        if (beat && col_tc && row_tc) begin
          state_d     = ST_IDLE;
          pend_done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (beat) begin
      dataout_valid_d = 1'b1;
      dataout_d       = (state_q == ST_DATA) ? pixel_in : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      cols_q          <= '0;
      rows_q          <= '0;
      pad_q           <= '0;
      w_q             <= '0;
      h_q             <= '0;
      dataout_q       <= '0;
      dataout_valid_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      pend_done_q     <= 1'b0;
      cfg_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      cols_q          <= cols_d;
      rows_q          <= rows_d;
      pad_q           <= pad_d;
      w_q             <= w_d;
      h_q             <= h_d;
      dataout_q       <= dataout_d;
      dataout_valid_q <= dataout_valid_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      pend_done_q     <= pend_done_d;
      cfg_err_q       <= cfg_err_d;
    end
  end

  assign initialize    = (state_q == ST_INIT);
  assign delay         = w_q[C_DIM_WIDTH-1:0];
  assign dataout       = dataout_q;
  assign dataout_valid = dataout_valid_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign cfg_err       = cfg_err_q;

endmodule

// File: tb/tb_row_feeder.sv
// Directed bench for row_feeder: a scoreboard of expected beats is filled at
// each frame start and drained as dataout_valid beats appear.
module tb_row_feeder;
  localparam int DW = 32;
  localparam int MD = 1024;
  localparam int NW = 10;
  localparam int PW = 3;

  logic          clk = 1'b0;
  logic          rst, start, pixel_in_valid, pixel_in_ready, out_en;
  logic          initialize, dataout_valid, busy, done, cfg_err;
  logic [NW-1:0] num_cols, num_rows, delay;
  logic [PW-1:0] pad;
  logic [DW-1:0] pixel_in, dataout;

  always #5 clk = ~clk;

  row_feeder #(.C_DATA_WIDTH(DW), .C_MAX_DIM(MD), .C_DIM_WIDTH(NW), .C_PAD_WIDTH(PW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_cols(num_cols), .num_rows(num_rows),
    .pad(pad), .pixel_in(pixel_in), .pixel_in_valid(pixel_in_valid),
    .pixel_in_ready(pixel_in_ready), .out_en(out_en), .initialize(initialize),
    .delay(delay), .dataout(dataout), .dataout_valid(dataout_valid), .busy(busy),
    .done(done), .cfg_err(cfg_err)
  );

  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] pix_next = 1;
  bit            bp = 1'b0;
  int            beats, init_cnt, done_cnt, cfg_cnt, first_valid, last_valid, done_cyc;
  logic          s_busy, s_init, s_cfg, s_done, s_valid;
  logic [NW-1:0] s_delay;
  logic [DW-1:0] s_dout;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic clear_stats();
    beats = 0; init_cnt = 0; done_cnt = 0; cfg_cnt = 0;
    first_valid = -1; last_valid = -1; done_cyc = -1;
  endtask

  // One clock: sample and score outputs on the falling edge, then drive the
  // next input pattern just after the rising edge.
  task automatic tick();
    logic fire;
    @(negedge clk);
    s_busy = busy; s_init = initialize; s_cfg = cfg_err; s_done = done;
    s_valid = dataout_valid; s_delay = delay; s_dout = dataout;
    if (dataout_valid) begin
      beats++;
      if (first_valid < 0) first_valid = cyc;
      last_valid = cyc;
      check("sb_nonempty", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) check("beat_data", 64'(dataout), 64'(exp_q.pop_front()));
    end
    if (initialize) init_cnt++;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (cfg_err) cfg_cnt++;
    if (!out_en) check("ready_low_when_out_en_low", 64'(pixel_in_ready), 64'(0));
    fire = pixel_in_valid && pixel_in_ready && !rst;
    @(posedge clk);
    #1;
    cyc++;
    if (fire) pix_next++;
    if (bp) begin
      out_en = ~out_en;
      pixel_in_valid = (cyc % 3) != 0;
    end else begin
      out_en = 1'b1;
      pixel_in_valid = 1'b1;
    end
    pixel_in = pix_next;
  endtask

  task automatic push_frame(input int c, input int r, input int p);
    logic [DW-1:0] v;
    v = pix_next;
    for (int y = 0; y < r + 2*p; y++) begin
      for (int x = 0; x < c + 2*p; x++) begin
        if (y >= p && y < p + r && x >= p && x < p + c) begin
          exp_q.push_back(v);
          v++;
        end else begin
          exp_q.push_back('0);
        end
      end
    end
  endtask

  task automatic start_frame(input int c, input int r, input int p, output int sc);
    num_cols = NW'(c); num_rows = NW'(r); pad = PW'(p);
    start = 1'b1;
    tick();
    start = 1'b0;
    sc = cyc;
  endtask

  task automatic wait_done(input int bound);
    for (int i = 0; i < bound && done_cnt == 0; i++) tick();
    check("done_within_bound", 64'(done_cnt != 0), 64'(1));
  endtask

  // Full frame run with all end-of-frame checks.
  task automatic run_frame(input int c, input int r, input int p, input int bound);
    int sc, w, h;
    w = c + 2*p; h = r + 2*p;
    clear_stats();
    push_frame(c, r, p);
    start_frame(c, r, p, sc);
    tick();
    check("busy_after_start", 64'(s_busy), 64'(1));
    check("initialize_after_start", 64'(s_init), 64'(1));
    check("delay_value", 64'(s_delay), 64'(w));
    wait_done(bound);
    check("beat_count", 64'(beats), 64'(w*h));
    check("initialize_count", 64'(init_cnt), 64'(1));
    check("first_valid_latency", 64'(first_valid - sc), 64'(2));
    check("done_after_last_beat", 64'(done_cyc - last_valid), 64'(1));
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    check("busy_low_with_done", 64'(s_busy), 64'(0));
    $display("frame cols=%0d rows=%0d pad=%0d bp=%0d beats=%0d", c, r, p, bp, beats);
    tick();
  endtask

  initial begin
    int sc;
    rst = 1'b1; start = 1'b0; out_en = 1'b1; pixel_in_valid = 1'b1; pixel_in = pix_next;
    num_cols = '0; num_rows = '0; pad = '0;
    clear_stats();
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_dataout", 64'(s_dout), 64'(0));
    check("rst_valid", 64'(s_valid), 64'(0));
    check("rst_initialize", 64'(s_init), 64'(0));
    check("rst_delay", 64'(s_delay), 64'(0));
    check("rst_busy", 64'(s_busy), 64'(0));
    check("rst_done", 64'(s_done), 64'(0));
    check("rst_cfg_err", 64'(s_cfg), 64'(0));

    run_frame(4, 3, 1, 200);
    run_frame(8, 2, 0, 200);
    bp = 1'b1;
    run_frame(4, 3, 1, 600);
    bp = 1'b0;
    tick();

    clear_stats();
    start_frame(1020, 2, 3, sc);
    tick();
    check("cfg_err_pulse", 64'(s_cfg), 64'(1));
    check("cfg_err_busy", 64'(s_busy), 64'(0));
    repeat (6) tick();
    check("cfg_err_no_beats", 64'(beats), 64'(0));
    check("cfg_err_once", 64'(cfg_cnt), 64'(1));
    $display("reject cols=1020 pad=3 cfg_err=%0d", cfg_cnt);

    clear_stats();
    start_frame(4, 0, 1, sc);
    tick();
    check("zero_rows_done", 64'(s_done), 64'(1));
    check("zero_rows_busy", 64'(s_busy), 64'(0));
    repeat (6) tick();
    check("zero_rows_no_beats", 64'(beats), 64'(0));
    check("zero_rows_no_init", 64'(init_cnt), 64'(0));
    $display("empty frame rows=0 done=%0d", done_cnt);

    clear_stats();
    push_frame(4, 3, 1);
    start_frame(4, 3, 1, sc);
    for (int i = 0; i < 100 && beats < 10; i++) tick();
    check("reached_beat_10", 64'(beats >= 10), 64'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("midrst_dataout", 64'(s_dout), 64'(0));
    check("midrst_valid", 64'(s_valid), 64'(0));
    check("midrst_busy", 64'(s_busy), 64'(0));
    check("midrst_delay", 64'(s_delay), 64'(0));
    check("midrst_initialize", 64'(s_init), 64'(0));
    check("midrst_done", 64'(s_done), 64'(0));
    $display("reset mid-frame after %0d beats", beats);
    exp_q.delete();
    repeat (2) tick();
    run_frame(4, 3, 1, 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
